// File: rtl/packing_result_bram.sv
// Packs narrow stream elements into wide words and stores them in an internal
// memory. The memory is read back on a wide, read-only port with one cycle of
// latency. Element k lands in word k/IN_WORD_DATA, lane k%IN_WORD_DATA, which
// is the same mapping the narrow reader uses.
//
// state   | meaning
// --------+--------------------------------------------------------------
// FILL    | accepting elements, packing lanes, flushing full/last words
// DONE    | buffer complete (s_last seen or memory full); waits for clear
module packing_result_bram #(
    parameter int PORT_B_WIDTH = 8,
    parameter int PORT_B_DEPTH = 256,
    parameter int PORT_B_ADDR  = $clog2(PORT_B_DEPTH),
    parameter int PORT_A_WIDTH = 32,
    parameter int IN_WORD_DATA = PORT_A_WIDTH / PORT_B_WIDTH,
    parameter int PORT_A_DEPTH = PORT_B_DEPTH / IN_WORD_DATA,
    parameter int PORT_A_ADDR  = $clog2(PORT_A_DEPTH)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clear,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PORT_B_WIDTH-1:0] s_data,
    input  logic                    s_last,
    input  logic                    ena,
    input  logic [PORT_A_ADDR-1:0]  addra,
    output logic [PORT_A_WIDTH-1:0] douta,
    output logic                    done,
    output logic [PORT_B_ADDR:0]    count
);

    localparam int LANE_W = (IN_WORD_DATA > 1) ? $clog2(IN_WORD_DATA) : 1;
    localparam logic [LANE_W-1:0]    LANE_LAST = LANE_W'(IN_WORD_DATA - 1);
    localparam logic [PORT_A_ADDR:0] WPTR_LAST = (PORT_A_ADDR + 1)'(PORT_A_DEPTH - 1);

    typedef enum logic {ST_FILL, ST_DONE} state_t;

    state_t                  state_q, state_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [PORT_A_ADDR:0]    wptr_q, wptr_d;
    logic [PORT_A_WIDTH-1:0] pack_q, pack_d;
    logic [PORT_B_ADDR:0]    count_q, count_d;
    logic [PORT_A_WIDTH-1:0] douta_q, douta_d;
    logic                    ready_en_q;

    logic [PORT_A_WIDTH-1:0] mem [PORT_A_DEPTH];
    logic [PORT_A_WIDTH-1:0] new_word;
    logic                    mem_we;
    logic                    accept;

    // Next-state, packing and write-enable logic.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        wptr_d   = wptr_q;
        pack_d   = pack_q;
        count_d  = count_q;
        mem_we   = 1'b0;
        s_ready  = ready_en_q && (state_q == ST_FILL) && !clear;
        accept   = s_valid && s_ready;
        new_word = pack_q;
        new_word[lane_q*PORT_B_WIDTH +: PORT_B_WIDTH] = s_data;

        if (clear) begin
            state_d = ST_FILL;
            lane_d  = '0;
            wptr_d  = '0;
            pack_d  = '0;
            count_d = '0;
        end else if (accept) begin
            count_d = count_q + (PORT_B_ADDR + 1)'(1);
            if (lane_q == LANE_LAST || s_last) begin
                mem_we = 1'b1;
                wptr_d = wptr_q + (PORT_A_ADDR + 1)'(1);
                lane_d = '0;
                pack_d = '0;
                if (s_last || wptr_q == WPTR_LAST)
                    state_d = ST_DONE;
            end else begin
                pack_d = new_word;
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    // Read port: hold when not enabled; reads see pre-write contents.
    always_comb begin
        douta_d = douta_q;
        if (ena)
            douta_d = mem[addra];
    end

    // Control and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_FILL;
            lane_q     <= '0;
            wptr_q     <= '0;
            pack_q     <= '0;
            count_q    <= '0;
            douta_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            wptr_q     <= wptr_d;
            pack_q     <= pack_d;
            count_q    <= count_d;
            douta_q    <= douta_d;
            ready_en_q <= 1'b1;
        end
    end

    // Word storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wptr_q[PORT_A_ADDR-1:0]] <= new_word;
    end

    assign douta = douta_q;
    assign done  = (state_q == ST_DONE);
    assign count = count_q;

endmodule
